hdmi_capture_controller: RTL and testbench



---
 rtl/hdmi_capture_controller_pkg.sv | 22 ++
 rtl/hdmi_capture_controller_sync_edge_detect.sv | 24 ++
 rtl/hdmi_capture_controller.sv | 158 +++++++++++++++
 tb/tb_hdmi_capture_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_capture_controller_pkg.sv
// hdmi_pkg: shared state type and default LCD geometry for the capture path.
// Exports capture_state_t, LCD_H_ACTIVE, LCD_V_ACTIVE and a packing check.
package hdmi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VSYNC,
        CAPTURE,
        DONE,
        ERROR
    } capture_state_t;

    localparam int LCD_H_ACTIVE = 800;
    localparam int LCD_V_ACTIVE = 480;

    // The ingester packs 4 pixels into 3 words; a frame must end on a
    // word boundary.
    function automatic bit packsEvenly(int h, int v);
        return ((h * v) % 4) == 0;
    endfunction

endpackage

// File: rtl/hdmi_capture_controller_sync_edge_detect.sv
// sync_edge_detect: registers a level and flags its rising/falling edges.
// Ports: i_clock, i_reset (sync, active-high), i_signal, o_rise, o_fall.
module sync_edge_detect (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_signal,
    output logic o_rise,
    output logic o_fall
);

    logic signalQ;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            signalQ <= 1'b0;
        end else begin
            signalQ <= i_signal;
        end
    end

    assign o_rise = i_signal & ~signalQ;
    assign o_fall = ~i_signal & signalQ;

endmodule

// File: rtl/hdmi_capture_controller.sv
// hdmi_capture_controller: frame sequencer gating the HDMI ingester/FIFO path.
// Ports: i_hdmiClock/i_reset, start/abort commands, vSync/DE/FIFO inputs;
// enable, busy, frameDone, sticky errors, pixel/line counters out.
module hdmi_capture_controller
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE          = LCD_H_ACTIVE,
    parameter int V_ACTIVE          = LCD_V_ACTIVE,
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
    parameter bit CONTINUOUS        = 1'b0,
    localparam int PW = $clog2(H_ACTIVE + 1),
    localparam int LW = $clog2(V_ACTIVE + 1)
) (
    input  logic          i_hdmiClock,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_vSync,
    input  logic          i_de,
    input  logic          i_fifoFull,
    input  logic          i_dataValid,
    output logic          o_hdmiEnable,
    output logic          o_busy,
    output logic          o_frameDone,
    output logic          o_overflow,
    output logic          o_syncError,
    output logic [PW-1:0] o_pixelCount,
    output logic [LW-1:0] o_lineCount
);

    if (!packsEvenly(H_ACTIVE, V_ACTIVE)) begin : g_badGeometry
        $error("H_ACTIVE*V_ACTIVE must be a multiple of 4");
    end

    capture_state_t state, stateNext;
    logic [PW-1:0]  pixelNext;
    logic [LW-1:0]  lineNext;
    logic           overflowNext;
    logic           syncErrorNext;

    logic vsNorm;
    logic vsRise, vsFall;
    logic deRiseUnused, deFall;
    logic pixelsFull;

    assign vsNorm = VSYNC_ACTIVE_HIGH ? i_vSync : ~i_vSync;
    assign pixelsFull = (o_pixelCount == PW'(H_ACTIVE));

    sync_edge_detect u_vsEdge (
        .i_clock  (i_hdmiClock),
        .i_reset  (i_reset),
        .i_signal (vsNorm),
        .o_rise   (vsRise),
        .o_fall   (vsFall)
    );

    sync_edge_detect u_deEdge (
        .i_clock  (i_hdmiClock),
        .i_reset  (i_reset),
        .i_signal (i_de),
        .o_rise   (deRiseUnused),
        .o_fall   (deFall)
    );

    always_comb begin
        stateNext     = state;
        pixelNext     = o_pixelCount;
        lineNext      = o_lineCount;
        overflowNext  = o_overflow;
        syncErrorNext = o_syncError;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    stateNext     = WAIT_VSYNC;
                    pixelNext     = '0;
                    lineNext      = '0;
                    overflowNext  = 1'b0;
                    syncErrorNext = 1'b0;
                end
            end
            WAIT_VSYNC: begin
                if (i_abort) begin
                    stateNext = IDLE;
                end else if (vsFall) begin
                    // Frame boundary: counters restart for this frame.
                    stateNext = CAPTURE;
                    pixelNext = '0;
                    lineNext  = '0;
                end
            end
            CAPTURE: begin
                if (i_abort) begin
                    stateNext = IDLE;
                end else if (i_fifoFull && i_dataValid) begin
                    stateNext    = ERROR;
                    overflowNext = 1'b1;
                end else if (vsRise ||
                             (deFall && !pixelsFull) ||
                             (i_de && pixelsFull)) begin
                    stateNext     = ERROR;
                    syncErrorNext = 1'b1;
                end else if (deFall) begin
                    pixelNext = '0;
                    lineNext  = o_lineCount + 1'b1;
                    if (lineNext == LW'(V_ACTIVE)) begin
                        stateNext = DONE;
                    end
                end else if (i_de) begin
                    pixelNext = o_pixelCount + 1'b1;
                end
            end
            DONE: begin
                if (i_abort) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = CONTINUOUS ? WAIT_VSYNC : IDLE;
                end
            end
            ERROR: begin
                if (i_abort) begin
                    stateNext = IDLE;
                end else if (i_start) begin
                    stateNext     = WAIT_VSYNC;
                    pixelNext     = '0;
                    lineNext      = '0;
                    overflowNext  = 1'b0;
                    syncErrorNext = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_hdmiClock) begin
        if (i_reset) begin
            state        <= IDLE;
            o_hdmiEnable <= 1'b0;
            o_busy       <= 1'b0;
            o_frameDone  <= 1'b0;
            o_overflow   <= 1'b0;
            o_syncError  <= 1'b0;
            o_pixelCount <= '0;
            o_lineCount  <= '0;
        end else begin
            state        <= stateNext;
            o_hdmiEnable <= (stateNext == CAPTURE);
            o_busy       <= (stateNext != IDLE);
            o_frameDone  <= (stateNext == DONE);
            o_overflow   <= overflowNext;
            o_syncError  <= syncErrorNext;
            o_pixelCount <= pixelNext;
            o_lineCount  <= lineNext;
        end
    end

endmodule

// File: tb/tb_hdmi_capture_controller.sv
// tb_hdmi_capture_controller: table-driven bench, H_ACTIVE=8, V_ACTIVE=4.
// Two instances: single-shot (A) and continuous (C) share the stimulus.
module tb_hdmi_capture_controller;

    localparam int H = 8;
    localparam int V = 4;

    logic clk = 1'b0;
    logic i_reset, i_start, i_abort, i_vSync;
    logic i_de, i_fifoFull, i_dataValid;

    logic       enA, busyA, doneA, ovfA, serrA;
    logic [3:0] pixA;
    logic [2:0] lineA;
    logic       enC, busyC, doneC, ovfC, serrC;
    logic [3:0] pixC;
    logic [2:0] lineC;

    always #5 clk = ~clk;

    hdmi_capture_controller #(
        .H_ACTIVE(H), .V_ACTIVE(V),
        .VSYNC_ACTIVE_HIGH(1'b1), .CONTINUOUS(1'b0)
    ) dutA (
        .i_hdmiClock(clk), .i_reset(i_reset),
        .i_start(i_start), .i_abort(i_abort),
        .i_vSync(i_vSync), .i_de(i_de),
        .i_fifoFull(i_fifoFull), .i_dataValid(i_dataValid),
        .o_hdmiEnable(enA), .o_busy(busyA),
        .o_frameDone(doneA), .o_overflow(ovfA),
        .o_syncError(serrA), .o_pixelCount(pixA),
        .o_lineCount(lineA)
    );

    hdmi_capture_controller #(
        .H_ACTIVE(H), .V_ACTIVE(V),
        .VSYNC_ACTIVE_HIGH(1'b1), .CONTINUOUS(1'b1)
    ) dutC (
        .i_hdmiClock(clk), .i_reset(i_reset),
        .i_start(i_start), .i_abort(i_abort),
        .i_vSync(i_vSync), .i_de(i_de),
        .i_fifoFull(i_fifoFull), .i_dataValid(i_dataValid),
        .o_hdmiEnable(enC), .o_busy(busyC),
        .o_frameDone(doneC), .o_overflow(ovfC),
        .o_syncError(serrC), .o_pixelCount(pixC),
        .o_lineCount(lineC)
    );

    typedef struct packed {
        logic rst, st, ab, vs, de, full, valid;
    } in_t;

    typedef struct packed {
        logic       en, busy, done, ovf, serr;
        logic [3:0] pix;
        logic [2:0] line;
    } out_t;

    typedef struct {
        string name;
        bit    sel;
        in_t   in;
        out_t  exp;
    } vec_t;

    out_t outA, outC;
    assign outA = {enA, busyA, doneA, ovfA, serrA, pixA, lineA};
    assign outC = {enC, busyC, doneC, ovfC, serrC, pixC, lineC};

    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;
    int   donePulsesC = 0;

    function automatic in_t mkIn(bit rst, bit st, bit ab, bit vs,
                                 bit de, bit full, bit valid);
        in_t r;
        r = {rst, st, ab, vs, de, full, valid};
        return r;
    endfunction

    function automatic out_t mkOut(bit en, bit busy, bit done, bit ovf,
                                   bit serr, int pix, int line);
        out_t r;
        r.en = en; r.busy = busy; r.done = done;
        r.ovf = ovf; r.serr = serr;
        r.pix = 4'(pix); r.line = 3'(line);
        return r;
    endfunction

    function automatic void add(string n, bit sel, in_t i, out_t e);
        vec_t v;
        v.name = n; v.sel = sel; v.in = i; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic in_t vd(bit vs, bit de);
        return mkIn(0, 0, 0, vs, de, 0, 0);
    endfunction

    // Start with vSync high, deassert it, then one blank capture cycle.
    function automatic void addArm(string n, bit sel);
        add(n, sel, mkIn(0, 1, 0, 1, 0, 0, 0), mkOut(0, 1, 0, 0, 0, 0, 0));
        add(n, sel, vd(0, 0), mkOut(1, 1, 0, 0, 0, 0, 0));
        add(n, sel, vd(0, 0), mkOut(1, 1, 0, 0, 0, 0, 0));
    endfunction

    function automatic void addLine(string n, bit sel, int l, bit last);
        for (int p = 0; p < H; p++)
            add(n, sel, vd(0, 1), mkOut(1, 1, 0, 0, 0, p + 1, l));
        if (last)
            add(n, sel, vd(0, 0), mkOut(0, 1, 1, 0, 0, 0, l + 1));
        else
            add(n, sel, vd(0, 0), mkOut(1, 1, 0, 0, 0, 0, l + 1));
    endfunction

    function automatic void addFrame(string n, bit sel);
        for (int l = 0; l < V; l++)
            addLine(n, sel, l, l == V - 1);
    endfunction

    task automatic runTable();
        out_t sb[$];
        out_t e, a;
        foreach (tbl[k]) begin
            {i_reset, i_start, i_abort, i_vSync,
             i_de, i_fifoFull, i_dataValid} = tbl[k].in;
            sb.push_back(tbl[k].exp);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            a = tbl[k].sel ? outC : outA;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s step %0d: got %h want %h",
                         tbl[k].name, k, a, e);
            end
            if (tbl[k].sel && a.done)
                donePulsesC++;
        end
    endtask

    initial begin
        out_t z;
        z = mkOut(0, 0, 0, 0, 0, 0, 0);
        {i_reset, i_start, i_abort, i_vSync,
         i_de, i_fifoFull, i_dataValid} = '0;

        // Reset state and one full frame.
        add("rstA", 0, mkIn(1, 0, 0, 0, 0, 0, 0), z);
        add("rstC", 1, mkIn(1, 0, 0, 0, 0, 0, 0), z);
        add("idle", 0, vd(0, 0), z);
        addArm("frame", 0);
        addFrame("frame", 0);
        add("postFrame", 0, vd(0, 0), mkOut(0, 0, 0, 0, 0, 0, 4));
        add("postFrame", 0, vd(0, 0), mkOut(0, 0, 0, 0, 0, 0, 4));

        // Start mid-frame, then abort keeps counters.
        add("mid", 0, mkIn(1, 0, 0, 0, 0, 0, 0), z);
        add("mid", 0, mkIn(0, 1, 0, 0, 1, 0, 0),
            mkOut(0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            add("mid", 0, vd(0, 1), mkOut(0, 1, 0, 0, 0, 0, 0));
        add("mid", 0, vd(0, 0), mkOut(0, 1, 0, 0, 0, 0, 0));
        add("mid", 0, vd(1, 0), mkOut(0, 1, 0, 0, 0, 0, 0));
        add("mid", 0, vd(0, 0), mkOut(1, 1, 0, 0, 0, 0, 0));
        add("mid", 0, vd(0, 0), mkOut(1, 1, 0, 0, 0, 0, 0));
        addLine("mid", 0, 0, 0);
        add("midAbort", 0, mkIn(0, 0, 1, 0, 0, 0, 0),
            mkOut(0, 0, 0, 0, 0, 0, 1));

        // Overflow on line 2, pixel 3.
        add("ovf", 0, mkIn(1, 0, 0, 0, 0, 0, 0), z);
        addArm("ovf", 0);
        addLine("ovf", 0, 0, 0);
        addLine("ovf", 0, 1, 0);
        add("ovf", 0, vd(0, 1), mkOut(1, 1, 0, 0, 0, 1, 2));
        add("ovf", 0, vd(0, 1), mkOut(1, 1, 0, 0, 0, 2, 2));
        add("ovfHit", 0, mkIn(0, 0, 0, 0, 1, 1, 1),
            mkOut(0, 1, 0, 1, 0, 2, 2));
        add("ovfHold", 0, vd(0, 1), mkOut(0, 1, 0, 1, 0, 2, 2));
        add("ovfHold", 0, vd(0, 0), mkOut(0, 1, 0, 1, 0, 2, 2));
        add("ovfRestart", 0, mkIn(0, 1, 0, 0, 0, 0, 0),
            mkOut(0, 1, 0, 0, 0, 0, 0));
        add("ovfAbort", 0, mkIn(0, 0, 1, 0, 0, 0, 0), z);

        // Short line, then long line.
        add("short", 0, mkIn(1, 0, 0, 0, 0, 0, 0), z);
        addArm("short", 0);
        for (int p = 0; p < H - 1; p++)
            add("short", 0, vd(0, 1), mkOut(1, 1, 0, 0, 0, p + 1, 0));
        add("shortErr", 0, vd(0, 0), mkOut(0, 1, 0, 0, 1, 7, 0));
        add("shortHold", 0, vd(0, 0), mkOut(0, 1, 0, 0, 1, 7, 0));
        addArm("reArm", 0);
        for (int p = 0; p < H; p++)
            add("long", 0, vd(0, 1), mkOut(1, 1, 0, 0, 0, p + 1, 0));
        add("longErr", 0, vd(0, 1), mkOut(0, 1, 0, 0, 1, 8, 0));
        add("errAbort", 0, mkIn(0, 0, 1, 0, 0, 0, 0),
            mkOut(0, 0, 0, 0, 1, 8, 0));

        // Early vSync inside the frame.
        add("early", 0, mkIn(1, 0, 0, 0, 0, 0, 0), z);
        addArm("early", 0);
        addLine("early", 0, 0, 0);
        add("earlyVs", 0, vd(1, 0), mkOut(0, 1, 0, 0, 1, 0, 1));

        // Continuous: three back-to-back frames.
        add("cont", 1, mkIn(1, 0, 0, 0, 0, 0, 0), z);
        addArm("cont", 1);
        addFrame("cont", 1);
        for (int f = 0; f < 2; f++) begin
            add("contGap", 1, vd(1, 0), mkOut(0, 1, 0, 0, 0, 0, 4));
            add("contGo", 1, vd(0, 0), mkOut(1, 1, 0, 0, 0, 0, 0));
            add("contGo", 1, vd(0, 0), mkOut(1, 1, 0, 0, 0, 0, 0));
            addFrame("cont", 1);
        end
        add("contWait", 1, vd(0, 0), mkOut(0, 1, 0, 0, 0, 0, 4));

        // Reset beats abort and overflow in the same cycle.
        add("rstMid", 0, mkIn(1, 0, 0, 0, 0, 0, 0), z);
        addArm("rstMid", 0);
        for (int p = 0; p < 3; p++)
            add("rstMid", 0, vd(0, 1), mkOut(1, 1, 0, 0, 0, p + 1, 0));
        add("rstWins", 0, mkIn(1, 0, 1, 0, 1, 1, 1), z);
        add("rstAfter", 0, vd(0, 0), z);

        runTable();

        total++;
        if (donePulsesC != 3) begin
            bad++;
            $display("FAIL contPulses: got %0d want 3", donePulsesC);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
